// File: rtl/mipi_csi_rx_pkg.sv
// Shared types and limits for the CSI-2 receive lane deskew slice.
//   deskew_state_e   : deskew controller states
//   DESKEW_MAX_DEPTH : largest supported delay-line length
package mipi_csi_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALIGN   = 2'd1,
        STREAM  = 2'd2,
        RECOVER = 2'd3
    } deskew_state_e;

    localparam int unsigned DESKEW_MAX_DEPTH = 16;

endpackage

// File: rtl/mipi_csi_rx_skew_line.sv
// One lane's delay line of {valid, data} with a selectable output tap.
// Stage 0 is the input registered once; every stage shifts every cycle.
//   clk_i, reset_n_i : byte clock, async active-low reset
//   i_valid, i_data  : lane word from the PHY
//   i_tap            : stage index presented on the outputs
//   o_valid_c, o_data_c : combinational view of the tapped stage
module mipi_csi_rx_skew_line #(
    parameter int unsigned MIPI_GEAR   = 16,
    parameter int unsigned ALIGN_DEPTH = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           i_valid,
    input  logic [MIPI_GEAR-1:0]           i_data,
    input  logic [$clog2(ALIGN_DEPTH)-1:0] i_tap,
    output logic                           o_valid_c,
    output logic [MIPI_GEAR-1:0]           o_data_c
);

    logic [ALIGN_DEPTH-1:0]                r_vld;
    logic [ALIGN_DEPTH-1:0][MIPI_GEAR-1:0] r_dat;

    // Free-running shift register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_vld <= '0;
            r_dat <= '0;
        end else begin
            r_vld <= {r_vld[ALIGN_DEPTH-2:0], i_valid};
            r_dat <= {r_dat[ALIGN_DEPTH-2:0], i_data};
        end
    end

    // Tap mux
    assign o_valid_c = r_vld[i_tap];
    assign o_data_c  = r_dat[i_tap];

endmodule

// File: rtl/mipi_csi_rx_lane_deskew.sv
// Per-lane deskew between the D-PHY word receivers and the CSI-2 decoder.
// Measures each lane's arrival offset at burst start and taps later stages
// of early lanes so all active lanes present word N on the same edge.
//   clk_i, reset_n_i : byte clock, async active-low reset
//   lanes_en_i       : active-lane mask, latched while idle
//   bytes_valid_i, lane_bytes_i : per-lane PHY words
//   lane_bytes_o, lane_valid_o  : aligned words (zero when not valid)
//   aligned_o        : streaming aligned data
//   err_skew_o       : pulse, skew too large to absorb
//   err_sync_o       : pulse, active lanes ended out of step (once per burst)
module mipi_csi_rx_lane_deskew
    import mipi_csi_rx_pkg::*;
#(
    parameter int unsigned MIPI_GEAR   = 16,
    parameter int unsigned MIPI_LANES  = 4,
    parameter int unsigned ALIGN_DEPTH = 8
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [MIPI_LANES-1:0]           lanes_en_i,
    input  logic [MIPI_LANES-1:0]           bytes_valid_i,
    input  logic [MIPI_GEAR*MIPI_LANES-1:0] lane_bytes_i,
    output logic [MIPI_GEAR*MIPI_LANES-1:0] lane_bytes_o,
    output logic [MIPI_LANES-1:0]           lane_valid_o,
    output logic                            aligned_o,
    output logic                            err_skew_o,
    output logic                            err_sync_o
);

    localparam int unsigned TW = $clog2(ALIGN_DEPTH);

    if (ALIGN_DEPTH < 2 || ALIGN_DEPTH > DESKEW_MAX_DEPTH) begin : g_bad_depth
        $error("ALIGN_DEPTH out of range");
    end

    deskew_state_e                    r_state;
    logic [TW-1:0]                    r_cnt;
    logic [MIPI_LANES-1:0]            r_en;
    logic [MIPI_LANES-1:0]            r_seen;
    logic [MIPI_LANES-1:0][TW-1:0]    r_arr;
    logic [MIPI_LANES-1:0][TW-1:0]    r_tap;
    logic                             r_sync_flag;

    logic [MIPI_LANES-1:0]                w_tv;
    logic [MIPI_LANES-1:0][MIPI_GEAR-1:0] w_td;
    logic [MIPI_LANES-1:0]                w_tv_act;
    logic [MIPI_LANES-1:0]                w_idle_vld;
    logic [MIPI_LANES-1:0]                w_act_vld;
    logic [MIPI_LANES-1:0]                w_seen_nxt;
    logic [TW-1:0]                        w_last;
    logic [MIPI_LANES-1:0][TW-1:0]        w_tap_new;
    logic [MIPI_GEAR*MIPI_LANES-1:0]      w_out_data;

    // Per-lane delay lines
    for (genvar g = 0; g < MIPI_LANES; g++) begin : g_lane
        mipi_csi_rx_skew_line #(
            .MIPI_GEAR   (MIPI_GEAR),
            .ALIGN_DEPTH (ALIGN_DEPTH)
        ) u_line (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .i_valid   (bytes_valid_i[g]),
            .i_data    (lane_bytes_i[g*MIPI_GEAR +: MIPI_GEAR]),
            .i_tap     (r_tap[g]),
            .o_valid_c (w_tv[g]),
            .o_data_c  (w_td[g])
        );
    end

    // In IDLE the mask is being latched this cycle, so decide on the live mask
    assign w_idle_vld = bytes_valid_i & lanes_en_i;
    assign w_act_vld  = bytes_valid_i & r_en;
    assign w_seen_nxt = r_seen | w_act_vld;
    assign w_tv_act   = w_tv & r_en;

    // Tap = latest arrival minus own arrival; lanes first seen now get tap 0
    always_comb begin
        w_last     = r_cnt + TW'(1);
        w_tap_new  = '0;
        w_out_data = '0;
        for (int i = 0; i < MIPI_LANES; i++) begin
            w_tap_new[i] = r_seen[i] ? TW'(w_last - r_arr[i]) : '0;
            w_out_data[i*MIPI_GEAR +: MIPI_GEAR] = w_tv_act[i] ? w_td[i] : '0;
        end
    end

    // Deskew controller and registered outputs
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_en         <= '0;
            r_seen       <= '0;
            r_arr        <= '0;
            r_tap        <= '0;
            r_sync_flag  <= 1'b0;
            lane_bytes_o <= '0;
            lane_valid_o <= '0;
            aligned_o    <= 1'b0;
            err_skew_o   <= 1'b0;
            err_sync_o   <= 1'b0;
        end else begin
            lane_bytes_o <= '0;
            lane_valid_o <= '0;
            aligned_o    <= 1'b0;
            err_skew_o   <= 1'b0;
            err_sync_o   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_en        <= lanes_en_i;
                    r_cnt       <= '0;
                    r_seen      <= '0;
                    r_arr       <= '0;
                    r_sync_flag <= 1'b0;
                    if (|w_idle_vld) begin
                        r_seen <= w_idle_vld;
                        if (w_idle_vld == lanes_en_i) begin
                            r_tap   <= '0;
                            r_state <= STREAM;
                        end else begin
                            r_state <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    r_cnt  <= w_last;
                    r_seen <= w_seen_nxt;
                    for (int i = 0; i < MIPI_LANES; i++) begin
                        if (w_act_vld[i] && !r_seen[i]) r_arr[i] <= w_last;
                    end
                    // Arrival cnt+1 would no longer fit a tap at the last count
                    if (r_cnt == TW'(ALIGN_DEPTH - 1)) begin
                        err_skew_o <= 1'b1;
                        r_state    <= RECOVER;
                    end else if (w_seen_nxt == r_en) begin
                        r_tap   <= w_tap_new;
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    lane_valid_o <= w_tv_act;
                    lane_bytes_o <= w_out_data;
                    aligned_o    <= |w_tv_act;
                    if (w_tv_act == '0) begin
                        r_state <= IDLE;
                    end else if (w_tv_act != r_en && !r_sync_flag) begin
                        err_sync_o  <= 1'b1;
                        r_sync_flag <= 1'b1;
                    end
                end
                RECOVER: begin
                    if (bytes_valid_i == '0) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
